// File: rtl/conv_encoder_framer_if.sv
`default_nettype none
// ============================================================================
// conv_encoder_framer_if : bit-load, start and symbol-stream handshake bundle
// Revision: 1.0
// ============================================================================
interface conv_encoder_framer_if #(
  parameter int CNT_W = 6
) ();
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             start;
  logic             sym_valid;
  logic [1:0]       sym_out;
  logic             sym_ready;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output in_valid, in_bit, start, sym_ready,
    input  in_ready, sym_valid, sym_out, busy, frame_done, bit_count
  );

  modport slave (
    input  in_valid, in_bit, start, sym_ready,
    output in_ready, sym_valid, sym_out, busy, frame_done, bit_count
  );
endinterface
`default_nettype wire

// File: rtl/conv_encoder_framer.sv
`default_nettype none
// ============================================================================
// conv_encoder_framer : buffers a frame and streams K=3 (7,5) rate-1/2 symbols
// Optional macro TAIL_FLUSH_EN appends two zero tail bits. Revision: 1.0
// ============================================================================
module conv_encoder_framer #(
  parameter int MAX_BITS = 32,
  parameter int CNT_W    = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_encoder_framer_if.slave bus
);

  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
`ifdef TAIL_FLUSH_EN
  localparam logic [CNT_W-1:0] TAIL_LEN = CNT_W'(2);
`else
  localparam logic [CNT_W-1:0] TAIL_LEN = CNT_W'(0);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_count_q, bit_count_d;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic [1:0]          enc_s_q, enc_s_d;
  logic [MAX_BITS-1:0] buf_q, buf_d;

  logic [CNT_W-1:0] sym_total;
  logic             have_sym;
  logic             cur_bit;
  logic [1:0]       sym_w;
  logic             in_ready_w;
  logic             xfer;

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    rd_idx_d    = rd_idx_q;
    enc_s_d     = enc_s_q;
    buf_d       = buf_q;

    sym_total  = bit_count_q + TAIL_LEN;
    have_sym   = (state_q == ST_ENCODE) && (rd_idx_q < sym_total);
    // Indices past the buffered bits are tail positions and encode as zero.
    cur_bit    = 1'b0;
    if (rd_idx_q < bit_count_q) begin
      cur_bit = buf_q[rd_idx_q[IDX_W-1:0]];
    end
    sym_w      = have_sym ? {enc_s_q[1] ^ enc_s_q[0] ^ cur_bit, enc_s_q[1] ^ cur_bit} : 2'b00;
    in_ready_w = (state_q == ST_IDLE) && (bit_count_q < CNT_W'(MAX_BITS));
    xfer       = have_sym && bus.sym_ready;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          buf_d[bit_count_q[IDX_W-1:0]] = bus.in_bit;
          bit_count_d                   = bit_count_q + CNT_W'(1);
        end
        if (bus.start) begin
          state_d  = ST_ENCODE;
          enc_s_d  = 2'b00;
          rd_idx_d = '0;
        end
      end
      ST_ENCODE: begin
        if (!have_sym) begin
          state_d = ST_DONE;
        end else if (xfer) begin
          enc_s_d  = {enc_s_q[0], cur_bit};
          rd_idx_d = rd_idx_q + CNT_W'(1);
          if ((rd_idx_q + CNT_W'(1)) == sym_total) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        bit_count_d = '0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_count_q <= '0;
      rd_idx_q    <= '0;
      enc_s_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      rd_idx_q    <= rd_idx_d;
      enc_s_q     <= enc_s_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.sym_valid  = have_sym;
  assign bus.sym_out    = sym_w;
  assign bus.busy       = (state_q == ST_ENCODE);
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.bit_count  = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_framer.sv
`default_nettype none
// ============================================================================
// tb_conv_encoder_framer : directed and random frames against a parity model
// Revision: 1.0
// ============================================================================
module tb_conv_encoder_framer;

  localparam int MAX_BITS = 32;
  localparam int CNT_W    = 6;
`ifdef TAIL_FLUSH_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_encoder_framer_if #(.CNT_W(CNT_W)) bus ();

  conv_encoder_framer #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int         n_checks = 0;
  int         n_errs   = 0;
  logic       bits_q[$];
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: 3-bit window (bit0 newest); G0=7 and G1=5 taps give parity by popcount.
  function automatic void build_expected();
    int w;
    logic b;
    exp_q.delete();
    w = 0;
    for (int i = 0; i < bits_q.size() + TAIL; i++) begin
      b = (i < bits_q.size()) ? bits_q[i] : 1'b0;
      w = ((w << 1) | int'(b)) & 7;
      exp_q.push_back({1'($countones(w & 7) & 1), 1'($countones(w & 5) & 1)});
    end
  endfunction

  task automatic load_bits();
    int n;
    n = bits_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = bits_q[i];
      check("in_ready_load", 32'(bus.in_ready), 32'(i < MAX_BITS));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bit_count_load", 32'(bus.bit_count), 32'((n < MAX_BITS) ? n : MAX_BITS));
    while (bits_q.size() > MAX_BITS) void'(bits_q.pop_back());
  endtask

  // mode 0: ready always, 1: toggle 1/0, 2: random. poke drives start/in_valid during ENCODE.
  task automatic run_frame(input int mode, input bit poke);
    int   k, n, cyc;
    logic r;
    n = exp_q.size();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    cyc = 0;
    if (n == 0) begin
      check("busy_empty", 32'(bus.busy), 32'd1);
      check("sym_valid_empty", 32'(bus.sym_valid), 32'd0);
      @(negedge clk);
    end else begin
      while (k < n) begin
        if (cyc > 4000) begin
          check("sym_timeout", 32'(k), 32'(n));
          break;
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = (cyc % 2 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        bus.sym_ready = r;
        if (poke) begin
          bus.start    = 1'b1;
          bus.in_valid = 1'b1;
          bus.in_bit   = 1'b1;
        end
        check("sym_valid", 32'(bus.sym_valid), 32'd1);
        check("busy", 32'(bus.busy), 32'd1);
        check("in_ready_enc", 32'(bus.in_ready), 32'd0);
        check($sformatf("sym_out[%0d]", k), 32'(bus.sym_out), 32'(exp_q[k]));
        if (r) k++;
        @(negedge clk);
        cyc++;
      end
    end
    bus.sym_ready = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    check("frame_done", 32'(bus.frame_done), 32'd1);
    check("sym_valid_done", 32'(bus.sym_valid), 32'd0);
    check("busy_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("frame_done_pulse", 32'(bus.frame_done), 32'd0);
    check("bit_count_clr", 32'(bus.bit_count), 32'd0);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic set_bits(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v;
    bits_q.delete();
    for (int i = 0; i < n; i++) bits_q.push_back(t[i]);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.start     = 1'b0;
    bus.sym_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("rst_sym_out", 32'(bus.sym_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_bit_count", 32'(bus.bit_count), 32'd0);
    rst_n = 1'b1;

    // Eight zeros.
    set_bits(32'h0, 8);
    load_bits();
    exp_q = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    if (TAIL == 2) begin exp_q.push_back(2'b00); exp_q.push_back(2'b00); end
    run_frame(0, 1'b0);

    // Single one (impulse response).
    set_bits(32'h1, 8);
    load_bits();
    exp_q = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    if (TAIL == 2) begin exp_q.push_back(2'b00); exp_q.push_back(2'b00); end
    run_frame(0, 1'b0);

    // 8'b10110100 LSB first.
    set_bits(32'hB4, 8);
    load_bits();
    exp_q = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    if (TAIL == 2) begin exp_q.push_back(2'b10); exp_q.push_back(2'b11); end
    run_frame(0, 1'b0);

    // All ones with sym_ready toggling.
    set_bits(32'hFF, 8);
    load_bits();
    exp_q = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    if (TAIL == 2) begin exp_q.push_back(2'b01); exp_q.push_back(2'b11); end
    run_frame(1, 1'b0);

    // Overflow: 34 bits offered, last two dropped; start/in_valid poked during ENCODE.
    bits_q.delete();
    for (int i = 0; i < MAX_BITS + 2; i++) bits_q.push_back(1'($urandom));
    load_bits();
    build_expected();
    run_frame(2, 1'b1);

    // Empty frame.
    bits_q.delete();
    build_expected();
    run_frame(0, 1'b0);

    // Reset after the third symbol of a 16-bit frame.
    bits_q.delete();
    for (int i = 0; i < 16; i++) bits_q.push_back(1'($urandom));
    load_bits();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.sym_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("abort_bit_count", 32'(bus.bit_count), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.sym_ready = 1'b0;
    rst_n = 1'b1;
    set_bits(32'hFF, 8);
    load_bits();
    exp_q = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    if (TAIL == 2) begin exp_q.push_back(2'b01); exp_q.push_back(2'b11); end
    run_frame(0, 1'b0);

    // Random frames with random backpressure.
    for (int f = 0; f < 8; f++) begin
      int len;
      len = int'($urandom_range(0, MAX_BITS));
      bits_q.delete();
      for (int i = 0; i < len; i++) bits_q.push_back(1'($urandom));
      load_bits();
      build_expected();
      run_frame(2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
- Transmit-side counterpart to the K=3 Viterbi decoder.
- Collects a frame of up to MAX_BITS information bits, then encodes them with the rate-1/2 convolutional code (K=3, G0=7, G1=5, LSB insertion) used by the decoder.
- Streams one 2-bit symbol per handshake, in the bit order the decoder expects.
- Sits between the data source and the decoder's symbol input in loopback/BIST builds.

Parameters:
- MAX_BITS, 32, maximum information bits per frame (buffer depth)
- CNT_W, 6, width of bit counters; must hold 0..MAX_BITS+2

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  information bit present on in_bit
- in_bit  input  1  information bit; first accepted bit is bit 0
- in_ready  output  1  block can accept an information bit
- start  input  1  one-cycle request to encode the buffered frame
- sym_valid  output  1  sym_out holds a valid symbol
- sym_out  output  2  {G0 parity, G1 parity}
- sym_ready  input  1  downstream consumes the symbol
- busy  output  1  high in ENCODE
- frame_done  output  1  one-cycle pulse after the last symbol is consumed
- bit_count  output  CNT_W  information bits currently buffered

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; in_ready=1; sym_valid=0; sym_out=00; busy=0; frame_done=0; bit_count=0; encoder state=00; buffer contents don't-care.
- Reset mid-frame: the asserted rst_n aborts immediately and returns everything to the reset values above. No partial symbols are emitted after release.
- FSM states: IDLE, ENCODE, DONE.
- IDLE:
  - in_ready = (bit_count < MAX_BITS).
  - in_valid && in_ready stores in_bit at index bit_count, and bit_count increments.
  - in_valid with buffer full is dropped; bit_count is unchanged.
  - start moves to ENCODE. The encoder state is cleared to 00, the read index to 0, and in_ready drops the next cycle.
  - start and in_valid in the same cycle: the bit is accepted first and is included in the frame.
- ENCODE:
  - busy=1, in_ready=0. in_valid and start are ignored.
  - sym_valid rises the cycle after start is accepted (1-cycle latency).
  - Encoding rule, with state s={s1,s0} and current bit b:
    - sym_out[1] = s1^s0^b
    - sym_out[0] = s1^b
    - next s = {s0,b}
  - sym_valid and sym_out stay stable while sym_valid && !sym_ready.
  - On sym_valid && sym_ready, the next symbol is presented in the following cycle. Back-to-back transfers run at 1 symbol/cycle.
  - After the final symbol is accepted: go to DONE, sym_valid=0.
- Empty frame: start with bit_count=0 goes to ENCODE, which emits no symbols (tail only if enabled) and proceeds to DONE.
- DONE:
  - frame_done=1 for exactly one cycle.
  - bit_count clears to 0.
  - Next state is IDLE.
- Arithmetic: encoder state is 2 bits. Counters never wrap because bit_count saturates at MAX_BITS.

Optional Feature:
- Macro: TAIL_FLUSH_EN.
- Defined: after the last information bit, K-1=2 zero tail bits are encoded. Two extra symbols are emitted and the encoder finishes in state 00. An empty frame emits 00,00. frame_done follows the second tail symbol.
- Undefined: exactly bit_count symbols are emitted, with no tail. This matches the decoder's unterminated-frame mode.

Test Plan:
- Reset, load 8 zero bits, start, sym_ready=1 -> 8 symbols all 00; busy high during the burst; frame_done pulse one cycle after the 8th symbol is accepted.
- Load bits 1,0,0,0,0,0,0,0 -> symbols 11,10,11,00,00,00,00,00.
- Load 8'b10110100 LSB first (bits 0,0,1,0,1,1,0,1) -> symbols 00,00,11,10,00,01,01,00. With TAIL_FLUSH_EN, add 10,11 (10 symbols total).
- Load 8'b11111111, then toggle sym_ready 1/0 every cycle -> symbols 11,01,10,10,10,10,10,10. sym_out is stable on stall cycles, with no duplicates or drops.
- Push 34 bits with in_valid held high -> in_ready falls after the 32nd; bit_count=32; the extra 2 bits are dropped. A start issued during ENCODE is ignored, and in_valid there is not accepted.
- Assert rst_n low after the 3rd symbol of a 16-bit frame -> sym_valid=0, bit_count=0, busy=0 immediately. A new 8-bit all-ones frame afterwards reproduces the symbols from the all-ones case above.
